// File: rtl/logger_ev_arbiter.sv
// logger_ev_arbiter: round-robin arbiter that feeds one registered event slot toward the logger packer.
// Build option LOGGER_ARB_CHAN_TAG_EN overwrites the top IDX_W bits of out_id with the source channel.
module logger_ev_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = 16,
    parameter int TS_W = 64,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      in_valid,
    output logic [N_CH-1:0]      in_ready,
    input  logic [N_CH*ID_W-1:0] in_id,
    input  logic [N_CH*TS_W-1:0] in_start_ts,
    input  logic [N_CH*TS_W-1:0] in_end_ts,
    input  logic [N_CH*TS_W-1:0] in_delta,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_id,
    output logic [TS_W-1:0]      out_start_ts,
    output logic [TS_W-1:0]      out_end_ts,
    output logic [TS_W-1:0]      out_delta,
    output logic [IDX_W-1:0]     out_chan
);

    // Handshake: a transfer happens on a rising edge where valid && ready. Producers never
    // look at ready to raise valid; in_ready is derived from in_valid and the slot state.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_d, win;
    logic [IDX_W:0]   scan;
    logic             found, load_en;
    logic [ID_W-1:0]  load_id;

    logic [ID_W-1:0] id_arr [N_CH];
    logic [TS_W-1:0] st_arr [N_CH];
    logic [TS_W-1:0] en_arr [N_CH];
    logic [TS_W-1:0] dl_arr [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign id_arr[g] = in_id[g*ID_W +: ID_W];
        assign st_arr[g] = in_start_ts[g*TS_W +: TS_W];
        assign en_arr[g] = in_end_ts[g*TS_W +: TS_W];
        assign dl_arr[g] = in_delta[g*TS_W +: TS_W];
    end

    // Scan from rr_ptr upward; the wrap uses a compare so non-power-of-2 N_CH works.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(N_CH)) begin
                scan = scan - (IDX_W+1)'(N_CH);
            end
            if (!found && in_valid[scan[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = scan[IDX_W-1:0];
            end
        end
    end

    assign load_en   = !rst && found && ((state_q == EMPTY) || out_ready);
    assign out_valid = (state_q == FULL);

    always_comb begin
        in_ready      = '0;
        in_ready[win] = load_en;
    end

`ifdef LOGGER_ARB_CHAN_TAG_EN
    assign load_id = {win, id_arr[win][ID_W-IDX_W-1:0]};
`else
    assign load_id = id_arr[win];
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr;
        if (load_en) begin
            state_d  = FULL;
            rr_ptr_d = (win == IDX_W'(N_CH-1)) ? '0 : win + 1'b1;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            rr_ptr       <= '0;
            out_id       <= '0;
            out_start_ts <= '0;
            out_end_ts   <= '0;
            out_delta    <= '0;
            out_chan     <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr  <= rr_ptr_d;
            // Payload registers keep their last value when the slot drains.
            if (load_en) begin
                out_id       <= load_id;
                out_start_ts <= st_arr[win];
                out_end_ts   <= en_arr[win];
                out_delta    <= dl_arr[win];
                out_chan     <= win;
            end
        end
    end

endmodule
